qed_consistency_checker: RTL

- Checks the duplicated-instruction stream against the original stream.
- Classifies each committed instruction as original or duplicate by decoding its register fields: originals use x1..x15, duplicates x16..x31.
- Keeps a shadow copy of architectural writebacks and counts originals and duplicates.
- When the two counts match, compares each original register xi with its duplicate x(i+16) and reports a consistency result to the formal property / bench layer.

---
 rtl/qed_consistency_checker.sv | 105 ++++++++++
 1 files changed

// File: rtl/qed_consistency_checker.sv
// Quick error detection checker: classifies committed instructions as original or duplicate,
// shadows register writebacks and compares xi against x(i+16) once both streams have caught up.
module qed_consistency_checker #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit_valid,
    input  logic [31:0]      commit_instr,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [CNT_W-1:0] orig_count,
    output logic [CNT_W-1:0] dup_count,
    output logic             qed_ready,
    output logic             qed_mismatch,
    output logic             qed_error,
    output logic             order_error,
    output logic             cnt_overflow
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    logic [XLEN-1:0]  shadow [32];
    logic [6:0]       opcode;
    logic [4:0]       rd, rs1, rs2;
    logic             use_rd, use_rs1, use_rs2;
    logic             any_dup, any_nz, is_orig, is_dup;
    logic             orig_sat, dup_sat, overflow_hit, order_hit;
    logic [CNT_W-1:0] orig_next, dup_next;
    logic             ready_c, any_diff;
    logic             unused_instr;

    assign opcode       = commit_instr[6:0];
    assign rd           = commit_instr[11:7];
    assign rs1          = commit_instr[19:15];
    assign rs2          = commit_instr[24:20];
    assign unused_instr = ^{commit_instr[31:25], commit_instr[14:12]};

    always_comb begin
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R:        begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_I, OP_LW: begin use_rd = 1'b1; use_rs1 = 1'b1; end
            OP_SW:       begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            default:     ;
        endcase
    end

    // Any upper-half register marks the instruction as a duplicate, even when mixed with originals.
    assign any_dup = (use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]);
    assign any_nz  = (use_rd && rd != 5'd0) || (use_rs1 && rs1 != 5'd0) || (use_rs2 && rs2 != 5'd0);
    assign is_dup  = commit_valid && any_dup;
    assign is_orig = commit_valid && any_nz && !any_dup;

    assign orig_sat     = &orig_count;
    assign dup_sat      = &dup_count;
    assign orig_next    = (is_orig && !orig_sat) ? orig_count + CNT_W'(1) : orig_count;
    assign dup_next     = (is_dup && !dup_sat) ? dup_count + CNT_W'(1) : dup_count;
    assign overflow_hit = (is_orig && orig_sat) || (is_dup && dup_sat);
    assign order_hit    = dup_next > orig_next;

    // Compare stage works on the already-registered state, so results trail the counters by one cycle.
    assign ready_c = (orig_count == dup_count) && (orig_count != '0) && !cnt_overflow;

    always_comb begin
        any_diff = 1'b0;
        for (int i = 1; i < 16; i++) begin
            any_diff = any_diff | (shadow[i] != shadow[i+16]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            orig_count   <= '0;
            dup_count    <= '0;
            qed_ready    <= 1'b0;
            qed_mismatch <= 1'b0;
            qed_error    <= 1'b0;
            order_error  <= 1'b0;
            cnt_overflow <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            orig_count   <= orig_next;
            dup_count    <= dup_next;
            cnt_overflow <= cnt_overflow | overflow_hit;
            order_error  <= order_error | order_hit;
            qed_ready    <= ready_c;
            qed_mismatch <= ready_c && any_diff;
            qed_error    <= qed_error | (ready_c && any_diff);
            if (wb_valid && wb_rd != 5'd0) begin
                shadow[wb_rd] <= wb_data;
            end
        end
    end

endmodule
